// File: rtl/obuf_pingpong.sv
// Double-buffered accumulating output buffer: array lanes fill one half while a drain engine streams the other.
// Optional: define OBUF_ZERO_ON_DRAIN_EN to clear every location the drain engine reads.
module obuf_pingpong #(
    parameter int ARRAY_M        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int BUF_ADDR_WIDTH = 8,
    parameter int GROUP_SIZE     = MEM_DATA_WIDTH / DATA_WIDTH,
    parameter int BUF_ID_W       = $clog2(ARRAY_M / GROUP_SIZE),
    parameter int MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + BUF_ID_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            buf_write_req,
    input  logic                            buf_write_accum,
    input  logic [BUF_ADDR_WIDTH-1:0]       buf_write_addr,
    input  logic [ARRAY_M*DATA_WIDTH-1:0]   buf_write_data,
    input  logic                            swap_valid,
    output logic                            swap_ready,
    input  logic [MEM_ADDR_WIDTH:0]         drain_len,
    output logic                            mem_rd_valid,
    input  logic                            mem_rd_ready,
    output logic [MEM_DATA_WIDTH-1:0]       mem_rd_data,
    output logic                            mem_rd_last,
    output logic                            drain_busy,
    output logic                            active_half
);
    localparam int NUM_GROUPS = ARRAY_M / GROUP_SIZE;
    localparam int GRP_W      = (BUF_ID_W > 0) ? BUF_ID_W : 1;
    localparam int LEN_W      = MEM_ADDR_WIDTH + 1;
    localparam logic [LEN_W-1:0] CAP = {1'b1, {MEM_ADDR_WIDTH{1'b0}}};

    typedef enum logic {S_IDLE, S_DRAIN} state_t;
    state_t r_state, w_state_next;

    logic                                   r_active_half;
    logic                                   r_wr_valid, r_wr_accum, r_wr_half;
    logic [BUF_ADDR_WIDTH-1:0]              r_wr_addr;
    logic [ARRAY_M-1:0][DATA_WIDTH-1:0]     r_wr_data;
    logic                                   r_fw_valid, r_fw_half;
    logic [BUF_ADDR_WIDTH-1:0]              r_fw_addr;
    logic [ARRAY_M-1:0][DATA_WIDTH-1:0]     r_fw_data;
    logic [ARRAY_M-1:0][DATA_WIDTH-1:0]     w_commit_data, w_base;
    logic                                   w_fwd_hit;
    logic [1:0][ARRAY_M-1:0][DATA_WIDTH-1:0] w_rd_q;

    logic                                   r_drain_half;
    logic [LEN_W-1:0]                       r_len, r_rd_idx, w_len_clamped;
    logic                                   r_infl_valid, r_infl_last;
    logic [GRP_W-1:0]                       r_infl_grp, w_drain_grp;
    logic [BUF_ADDR_WIDTH-1:0]              w_drain_addr;
    logic [NUM_GROUPS-1:0][MEM_DATA_WIDTH-1:0] w_grp_word;
    logic [MEM_DATA_WIDTH-1:0]              w_drain_word;
    logic [1:0][MEM_DATA_WIDTH-1:0]         r_fifo_data;
    logic [1:0]                             r_fifo_last, r_fifo_cnt;
    logic                                   r_fifo_wptr, r_fifo_rptr;
    logic [2:0]                             w_occ;
    logic                                   w_issue, w_pop, w_swap_acc;
    logic                                   w_zero_any;
    logic [BUF_ADDR_WIDTH-1:0]              w_zero_addr;
    logic [GRP_W-1:0]                       w_zero_grp;

    assign active_half   = r_active_half;
    assign w_len_clamped = (drain_len > CAP) ? CAP : drain_len;
    assign w_drain_addr  = r_rd_idx[BUF_ID_W +: BUF_ADDR_WIDTH];
    assign mem_rd_valid  = (r_fifo_cnt != 2'd0);
    assign mem_rd_data   = r_fifo_data[r_fifo_rptr];
    assign mem_rd_last   = mem_rd_valid && r_fifo_last[r_fifo_rptr];
    assign w_pop         = mem_rd_valid && mem_rd_ready;
    assign w_swap_acc    = swap_valid && swap_ready;
    assign w_drain_word  = w_grp_word[r_infl_grp];
    assign w_occ         = {1'b0, r_fifo_cnt} + {2'b00, r_infl_valid} - {2'b00, w_pop};
    // Hold off drain reads while the accept-cycle write is still committing into the drained half.
    assign w_issue = (r_state == S_DRAIN) && (r_rd_idx < r_len) && (w_occ < 3'd2)
                     && !(r_wr_valid && (r_wr_half == r_drain_half));

    generate
        if (BUF_ID_W > 0) begin : g_grp
            assign w_drain_grp = r_rd_idx[GRP_W-1:0];
        end else begin : g_nogrp
            assign w_drain_grp = 1'b0;
        end
    endgenerate

    // A commit one cycle earlier to the same half/address was invisible to this request's RAM read.
    always_comb begin
        w_fwd_hit = r_fw_valid && (r_fw_half == r_wr_half) && (r_fw_addr == r_wr_addr);
        for (int m = 0; m < ARRAY_M; m++) begin
            w_base[m]        = w_fwd_hit ? r_fw_data[m] : w_rd_q[r_wr_half][m];
            w_commit_data[m] = r_wr_accum ? (w_base[m] + r_wr_data[m]) : r_wr_data[m];
        end
    end

    always_comb begin
        w_state_next = r_state;
        swap_ready   = 1'b0;
        drain_busy   = 1'b0;
        case (r_state)
            S_IDLE: begin
                swap_ready = 1'b1;
                if (swap_valid && (w_len_clamped != '0)) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                drain_busy = 1'b1;
                if (w_pop && mem_rd_last) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active_half <= 1'b0;
            r_wr_valid    <= 1'b0;
            r_wr_accum    <= 1'b0;
            r_wr_half     <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_fw_valid    <= 1'b0;
            r_fw_half     <= 1'b0;
            r_fw_addr     <= '0;
            r_fw_data     <= '0;
            r_drain_half  <= 1'b0;
            r_len         <= '0;
            r_rd_idx      <= '0;
            r_infl_valid  <= 1'b0;
            r_infl_last   <= 1'b0;
            r_infl_grp    <= '0;
            r_fifo_data   <= '0;
            r_fifo_last   <= '0;
            r_fifo_cnt    <= '0;
            r_fifo_wptr   <= 1'b0;
            r_fifo_rptr   <= 1'b0;
        end else begin
            r_wr_valid <= buf_write_req;
            if (buf_write_req) begin
                r_wr_accum <= buf_write_accum;
                r_wr_half  <= r_active_half;
                r_wr_addr  <= buf_write_addr;
                r_wr_data  <= buf_write_data;
            end
            r_fw_valid <= r_wr_valid;
            if (r_wr_valid) begin
                r_fw_half <= r_wr_half;
                r_fw_addr <= r_wr_addr;
                r_fw_data <= w_commit_data;
            end
            if (w_swap_acc) begin
                r_active_half <= ~r_active_half;
                r_drain_half  <= r_active_half;
                r_len         <= w_len_clamped;
                r_rd_idx      <= '0;
            end else if (w_issue) begin
                r_rd_idx <= r_rd_idx + LEN_W'(1);
            end
            r_infl_valid <= w_issue;
            if (w_issue) begin
                r_infl_last <= ((r_rd_idx + LEN_W'(1)) == r_len);
                r_infl_grp  <= w_drain_grp;
            end
            if (r_infl_valid) begin
                r_fifo_data[r_fifo_wptr] <= w_drain_word;
                r_fifo_last[r_fifo_wptr] <= r_infl_last;
                r_fifo_wptr              <= ~r_fifo_wptr;
            end
            if (w_pop) r_fifo_rptr <= ~r_fifo_rptr;
            r_fifo_cnt <= r_fifo_cnt + 2'(r_infl_valid) - 2'(w_pop);
        end
    end

`ifdef OBUF_ZERO_ON_DRAIN_EN
    logic                      r_zero_valid;
    logic [BUF_ADDR_WIDTH-1:0] r_zero_addr;
    logic [GRP_W-1:0]          r_zero_grp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_zero_valid <= 1'b0;
            r_zero_addr  <= '0;
            r_zero_grp   <= '0;
        end else begin
            r_zero_valid <= w_issue;
            r_zero_addr  <= w_drain_addr;
            r_zero_grp   <= w_drain_grp;
        end
    end
    assign w_zero_any  = r_zero_valid;
    assign w_zero_addr = r_zero_addr;
    assign w_zero_grp  = r_zero_grp;
`else
    assign w_zero_any  = 1'b0;
    assign w_zero_addr = '0;
    assign w_zero_grp  = '0;
`endif

    genvar gh, gi;
    generate
        for (gi = 0; gi < ARRAY_M; gi++) begin : g_word
            assign w_grp_word[gi / GROUP_SIZE][(gi % GROUP_SIZE)*DATA_WIDTH +: DATA_WIDTH] =
                w_rd_q[r_drain_half][gi];
        end
        // The active half's read port serves the array side; the other half serves the drain engine.
        for (gh = 0; gh < 2; gh++) begin : g_half
            for (gi = 0; gi < ARRAY_M; gi++) begin : g_lane
                logic [DATA_WIDTH-1:0]     r_ram [0:(1<<BUF_ADDR_WIDTH)-1];
                logic [DATA_WIDTH-1:0]     r_q;
                logic                      w_cwe, w_zwe;
                logic [BUF_ADDR_WIDTH-1:0] w_raddr;

                assign w_cwe   = r_wr_valid && (r_wr_half == 1'(gh));
                assign w_zwe   = w_zero_any && (r_drain_half == 1'(gh))
                                 && (w_zero_grp == GRP_W'(gi / GROUP_SIZE));
                assign w_raddr = (r_active_half == 1'(gh)) ? buf_write_addr : w_drain_addr;
                assign w_rd_q[gh][gi] = r_q;

                always_ff @(posedge clk) begin
                    if (w_cwe)      r_ram[r_wr_addr]   <= w_commit_data[gi];
                    else if (w_zwe) r_ram[w_zero_addr] <= '0;
                    r_q <= r_ram[w_raddr];
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_obuf_pingpong.sv
// Scoreboard bench for obuf_pingpong: a behavioural RAM model predicts every drained word.
`timescale 1ns/1ps
module tb_obuf_pingpong;
    localparam int M = 4, DW = 32, MDW = 64, BAW = 8, LW = 10;

    typedef logic [M-1:0][DW-1:0] lanes_t;
    typedef struct packed {
        logic [MDW-1:0] data;
        logic           last;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           buf_write_req = 1'b0, buf_write_accum = 1'b0;
    logic [BAW-1:0] buf_write_addr = '0;
    logic [M*DW-1:0] buf_write_data = '0;
    logic           swap_valid = 1'b0, swap_ready;
    logic [LW-1:0]  drain_len = '0;
    logic           mem_rd_valid, mem_rd_ready = 1'b1, mem_rd_last;
    logic [MDW-1:0] mem_rd_data;
    logic           drain_busy, active_half;

    exp_t           exp_q[$];
    logic [DW-1:0]  m_ram [2][256][M];
    logic           m_active = 1'b0;
    logic [MDW-1:0] cap_words [1024];
    int             n_tests = 0, n_fail = 0;

    obuf_pingpong dut (
        .clk(clk), .reset(reset),
        .buf_write_req(buf_write_req), .buf_write_accum(buf_write_accum),
        .buf_write_addr(buf_write_addr), .buf_write_data(buf_write_data),
        .swap_valid(swap_valid), .swap_ready(swap_ready), .drain_len(drain_len),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready),
        .mem_rd_data(mem_rd_data), .mem_rd_last(mem_rd_last),
        .drain_busy(drain_busy), .active_half(active_half)
    );

    always #5 clk = ~clk;

    function automatic lanes_t all_lanes(input logic [DW-1:0] v);
        lanes_t d;
        for (int m = 0; m < M; m++) d[m] = v;
        return d;
    endfunction

    task automatic model_write(input logic [BAW-1:0] addr, input logic acc, input lanes_t d);
        for (int m = 0; m < M; m++)
            m_ram[m_active][addr][m] = acc ? (m_ram[m_active][addr][m] + d[m]) : d[m];
    endtask

    task automatic do_write(input logic [BAW-1:0] addr, input logic acc, input lanes_t d);
        buf_write_req = 1'b1; buf_write_accum = acc; buf_write_addr = addr; buf_write_data = d;
        model_write(addr, acc, d);
        @(posedge clk); #1;
        buf_write_req = 1'b0; buf_write_accum = 1'b0;
    endtask

    task automatic do_swap(input int len, input bit wr, input logic [BAW-1:0] addr, input lanes_t d);
        int l, a, g;
        logic [MDW-1:0] wd;
        n_tests++;
        if (swap_ready !== 1'b1) begin
            n_fail++; $display("FAIL swap_ready_idle: got %b want 1", swap_ready);
        end
        if (wr) begin
            buf_write_req = 1'b1; buf_write_accum = 1'b0; buf_write_addr = addr; buf_write_data = d;
            model_write(addr, 1'b0, d);
        end
        swap_valid = 1'b1;
        drain_len  = LW'(len);
        l = (len > 512) ? 512 : len;
        for (int w = 0; w < l; w++) begin
            a  = w >> 1;
            g  = w & 1;
            wd = {m_ram[m_active][a][2*g+1], m_ram[m_active][a][2*g]};
            exp_q.push_back('{data: wd, last: (w == l - 1)});
`ifdef OBUF_ZERO_ON_DRAIN_EN
            m_ram[m_active][a][2*g]   = '0;
            m_ram[m_active][a][2*g+1] = '0;
`endif
        end
        m_active = ~m_active;
        @(posedge clk); #1;
        swap_valid = 1'b0; buf_write_req = 1'b0;
        n_tests++;
        if (active_half !== m_active) begin
            n_fail++; $display("FAIL active_half_toggle: got %b want %b", active_half, m_active);
        end
        $display("[TB] swap len=%0d clamped=%0d now active_half=%b", len, l, m_active);
    endtask

    task automatic drain_run(input bit rnd, input bit try_swap, output int nwords, output int span);
        int cyc = 0, first = -1;
        bit done = 0, hold = 0;
        logic [MDW-1:0] hold_data;
        logic hold_last;
        exp_t e;
        nwords = 0; span = 0;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            if (hold) begin
                n_tests++;
                if (!mem_rd_valid || mem_rd_data !== hold_data || mem_rd_last !== hold_last) begin
                    n_fail++;
                    $display("FAIL stall_stable: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             mem_rd_valid, mem_rd_data, mem_rd_last, hold_data, hold_last);
                end
            end
            if (mem_rd_valid && mem_rd_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL extra_word: got %h want none", mem_rd_data);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_rd_data !== e.data || mem_rd_last !== e.last) begin
                        n_fail++;
                        $display("FAIL drain_word[%0d]: got %h last=%b want %h last=%b",
                                 nwords, mem_rd_data, mem_rd_last, e.data, e.last);
                    end
                    if (e.last) begin
                        done = 1;
                        span = cyc - ((first < 0) ? cyc : first) + 1;
                    end
                end
                if (nwords < 1024) cap_words[nwords] = mem_rd_data;
                if (first < 0) first = cyc;
                nwords++;
            end
            if (!done) begin
                n_tests++;
                if (swap_ready !== 1'b0) begin
                    n_fail++; $display("FAIL swap_ready_busy: got %b want 0", swap_ready);
                end
            end
            if (try_swap) begin
                n_tests++;
                if (active_half !== m_active) begin
                    n_fail++; $display("FAIL swap_during_drain: active_half got %b want %b", active_half, m_active);
                end
            end
            hold      = mem_rd_valid && !mem_rd_ready;
            hold_data = mem_rd_data;
            hold_last = mem_rd_last;
            @(posedge clk); #1;
            cyc++;
            if (rnd) mem_rd_ready = 1'($urandom_range(0, 1));
            swap_valid = (try_swap && !done && nwords >= 3 && nwords < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        swap_valid   = 1'b0;
        mem_rd_ready = 1'b1;
        n_tests++;
        if (!done) begin
            n_fail++; $display("FAIL drain_timeout: got %0d words want last within 4000 cycles", nwords);
        end
        n_tests++;
        if (drain_busy !== 1'b0 || swap_ready !== 1'b1 || mem_rd_valid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_end_idle: got busy=%b ready=%b valid=%b pending=%0d want 0 1 0 0",
                     drain_busy, swap_ready, mem_rd_valid, exp_q.size());
        end
        $display("[TB] drain done words=%0d span=%0d", nwords, span);
    endtask

    task automatic check64(input string name, input logic [MDW-1:0] got, input logic [MDW-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++; $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (mem_rd_valid !== 1'b0 || mem_rd_last !== 1'b0 || mem_rd_data !== '0 ||
            drain_busy !== 1'b0 || swap_ready !== 1'b1 || active_half !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b l=%b d=%h busy=%b rdy=%b half=%b want 0 0 0 0 1 0",
                     mem_rd_valid, mem_rd_last, mem_rd_data, drain_busy, swap_ready, active_half);
        end
        @(posedge clk); #1;
    endtask

    task automatic init_fill();
        for (int h = 0; h < 2; h++) begin
            for (int a = 0; a < 256; a++) do_write(8'(a), 1'b0, '0);
            do_swap(0, 1'b0, '0, '0);
            n_tests++;
            if (drain_busy !== 1'b0) begin
                n_fail++; $display("FAIL zero_len_swap: drain_busy got %b want 0", drain_busy);
            end
        end
    endtask

    task automatic test_word_map();
        int nw, sp;
        lanes_t d;
        d[0] = 32'd1; d[1] = 32'd2; d[2] = 32'd3; d[3] = 32'd4;
        do_write(8'd5, 1'b0, d);
        do_swap(12, 1'b0, '0, '0);
        drain_run(1'b0, 1'b0, nw, sp);
        check64("word_map_w10", cap_words[10], 64'h00000002_00000001);
        check64("word_map_w11", cap_words[11], 64'h00000004_00000003);
        check64("word_map_count", 64'(nw), 64'd12);
        check64("word_map_span", 64'(sp), 64'd12);
    endtask

    task automatic test_accum_forward();
        int nw, sp;
        lanes_t d;
        do_write(8'd7, 1'b0, all_lanes(32'd10));
        do_write(8'd7, 1'b1, all_lanes(32'd3));
        do_write(8'd7, 1'b1, all_lanes(32'd4));
        do_write(8'd9, 1'b0, all_lanes(32'hFFFF_FFFF));
        do_write(8'd9, 1'b1, all_lanes(32'd1));
        d[0] = 32'd5; d[1] = 32'd6; d[2] = 32'd7; d[3] = 32'd8;
        do_swap(20, 1'b1, 8'd8, d);
        drain_run(1'b0, 1'b0, nw, sp);
        check64("accum_fwd_w14", cap_words[14], {32'd17, 32'd17});
        check64("accum_fwd_w15", cap_words[15], {32'd17, 32'd17});
        check64("accept_cycle_write_w16", cap_words[16], {32'd6, 32'd5});
        check64("accept_cycle_write_w17", cap_words[17], {32'd8, 32'd7});
        check64("accum_wrap_w18", cap_words[18], 64'h0);
    endtask

    task automatic test_random_stall();
        int nw, sp;
        lanes_t d;
        for (int a = 0; a < 32; a++) begin
            for (int m = 0; m < M; m++) d[m] = 32'($urandom);
            do_write(8'(a), 1'b0, d);
        end
        mem_rd_ready = 1'b0;
        do_swap(64, 1'b0, '0, '0);
        drain_run(1'b1, 1'b1, nw, sp);
        check64("stall_count", 64'(nw), 64'd64);
    endtask

    task automatic test_clamp();
        int nw, sp;
        do_swap(1023, 1'b0, '0, '0);
        drain_run(1'b0, 1'b0, nw, sp);
        check64("clamp_count", 64'(nw), 64'd512);
        check64("clamp_span", 64'(sp), 64'd512);
    endtask

    task automatic test_zero_on_drain();
        int nw, sp;
        do_write(8'd100, 1'b0, all_lanes(32'd7));
        do_swap(202, 1'b0, '0, '0);
        drain_run(1'b0, 1'b0, nw, sp);
        do_swap(0, 1'b0, '0, '0);
        do_write(8'd100, 1'b1, all_lanes(32'd5));
        do_swap(202, 1'b0, '0, '0);
        drain_run(1'b0, 1'b0, nw, sp);
`ifdef OBUF_ZERO_ON_DRAIN_EN
        check64("zero_on_drain_w200", cap_words[200], {32'd5, 32'd5});
`else
        check64("persist_w200", cap_words[200], {32'd12, 32'd12});
`endif
    endtask

    task automatic test_reset_mid_drain();
        mem_rd_ready = 1'b0;
        do_swap(40, 1'b0, '0, '0);
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (mem_rd_valid !== 1'b1 || drain_busy !== 1'b1) begin
            n_fail++; $display("FAIL pre_abort: got valid=%b busy=%b want 1 1", mem_rd_valid, drain_busy);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (mem_rd_valid !== 1'b0 || swap_ready !== 1'b1 || drain_busy !== 1'b0 || active_half !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: got valid=%b rdy=%b busy=%b half=%b want 0 1 0 0",
                     mem_rd_valid, swap_ready, drain_busy, active_half);
        end
        exp_q.delete();
        m_active = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        mem_rd_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (mem_rd_valid !== 1'b0 || swap_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_abort_idle: got valid=%b rdy=%b want 0 1", mem_rd_valid, swap_ready);
        end
    endtask

    initial begin
        test_reset();
        init_fill();
        test_word_map();
        test_accum_forward();
        test_random_stall();
        test_clamp();
        test_zero_on_drain();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
